// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Receive entry layout, FIFO depth and FCR trigger-level thresholds.
package uart_pkg;

  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // FCR[7:6] encodes 1, 4, 8 or 14 entries.
  localparam logic [3:0][4:0] TRIG_LVL = {5'd14, 5'd8, 5'd4, 5'd1};

  function automatic logic [4:0] trig_thresh(input logic [1:0] lvl);
    return TRIG_LVL[lvl];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with a combinational head and an occupancy count.
// A pop frees its slot in the same cycle, so push is accepted when full if pop is set too.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the head is qualified by empty downstream.
  always_ff @(posedge clk) begin
    if (do_push && !clr && !rst) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16550 receive buffer: FIFO or single holding register, with LSR receive bits,
// trigger-level status and character-timeout status for the interrupt logic.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int DEPTH         = FIFO_DEPTH,
  parameter int TIMEOUT_TICKS = 640,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  input  logic          wr_pe,
  input  logic          wr_fe,
  input  logic          rd_en,
  input  logic          lsr_rd,
  input  logic          fifo_en,
  input  logic          fifo_clr,
  input  logic [1:0]    trig_level,
  input  logic          baud_tick,
  output logic [7:0]    rd_data,
  output logic          rd_pe,
  output logic          rd_fe,
  output logic          data_avail,
  output logic          overrun,
  output logic          err_in_fifo,
  output logic [CW-1:0] count,
  output logic          trig_hit,
  output logic          char_timeout
);

  localparam logic [9:0] TO_MAX = 10'(TIMEOUT_TICKS);

  logic          fen_q, flush;
  logic          f_full, f_empty;
  logic          wr_ok, rd_ok, at_cap, push, pop, ovr_evt, push_err, pop_err;
  logic [CW-1:0] f_cnt, err_cnt;
  logic [9:0]    to_cnt;
  rx_entry_t     wentry, head;

  // Any FCR[0] transition empties the buffer, same as an explicit clear.
  assign flush  = fifo_clr | (fifo_en ^ fen_q);
  assign wentry = '{fe: wr_fe, pe: wr_pe, data: wr_data};

  // Non-FIFO mode is the same storage capped at one entry.
  assign at_cap  = fifo_en ? f_full : ~f_empty;
  assign wr_ok   = wr_valid & ~flush;
  assign rd_ok   = rd_en & ~f_empty & ~flush;
  assign ovr_evt = wr_ok & at_cap & ~rd_ok;
  assign push    = wr_ok & (~at_cap | rd_ok | ~fifo_en);
  // A holding-register overwrite is a pop of the stale character plus a push.
  assign pop     = rd_ok | (wr_ok & ~fifo_en & at_cap);

  assign push_err = push & (wr_pe | wr_fe);
  assign pop_err  = pop & (head.pe | head.fe);

  sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (wentry),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty),
    .count (f_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fen_q   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      fen_q   <= fifo_en;
      overrun <= ovr_evt | (overrun & ~lsr_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      err_cnt <= '0;
    end else begin
      case ({push_err, pop_err})
        2'b10:   err_cnt <= err_cnt + CW'(1);
        2'b01:   err_cnt <= err_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Idle timer counts baud ticks only while data sits untouched.
  always_ff @(posedge clk) begin
    if (rst || flush || wr_valid || rd_en || f_empty) begin
      to_cnt <= '0;
    end else if (baud_tick && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 10'd1;
    end
  end

  assign rd_data      = f_empty ? 8'h00 : head.data;
  assign rd_pe        = ~f_empty & head.pe;
  assign rd_fe        = ~f_empty & head.fe;
  assign data_avail   = ~f_empty;
  assign count        = f_cnt;
  assign err_in_fifo  = (err_cnt != '0);
  assign trig_hit     = fifo_en & (f_cnt >= CW'(trig_thresh(trig_level)));
  assign char_timeout = fifo_en & ~f_empty & (to_cnt == TO_MAX);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus a randomized run
// checked against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  localparam int TO = 640;

  logic       clk = 1'b0;
  logic       rst, wr_valid, wr_pe, wr_fe, rd_en, lsr_rd, fifo_en, fifo_clr, baud_tick;
  logic [7:0] wr_data;
  logic [1:0] trig_level;
  logic [7:0] rd_data;
  logic       rd_pe, rd_fe, data_avail, overrun, err_in_fifo, trig_hit, char_timeout;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;

  logic [9:0] mq[$];
  bit         m_ovr;
  int         m_to;
  bit         m_en;
  int         thr[4] = '{1, 4, 8, 14};

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_pe(wr_pe),
    .wr_fe(wr_fe), .rd_en(rd_en), .lsr_rd(lsr_rd), .fifo_en(fifo_en),
    .fifo_clr(fifo_clr), .trig_level(trig_level), .baud_tick(baud_tick),
    .rd_data(rd_data), .rd_pe(rd_pe), .rd_fe(rd_fe), .data_avail(data_avail),
    .overrun(overrun), .err_in_fifo(err_in_fifo), .count(count),
    .trig_hit(trig_hit), .char_timeout(char_timeout)
  );

  always #5 clk = ~clk;

  // Reference: a queue holding what the host would read, plus the sticky and idle state.
  task automatic mdl_step();
    int had;
    bit popped, flush, ov;
    logic [9:0] e;
    if (rst) begin
      mq.delete(); m_ovr = 0; m_to = 0; m_en = 0;
      return;
    end
    flush = fifo_clr || (fifo_en != m_en);
    m_en  = fifo_en;
    had   = mq.size();
    if (flush) begin
      mq.delete(); m_to = 0; m_ovr = m_ovr && !lsr_rd;
      return;
    end
    e = {wr_fe, wr_pe, wr_data};
    ov = 0;
    popped = rd_en && had > 0;
    if (popped) void'(mq.pop_front());
    if (wr_valid) begin
      if (had >= (fifo_en ? 16 : 1) && !popped) begin
        ov = 1;
        if (!fifo_en) begin
          void'(mq.pop_front());
          mq.push_back(e);
        end
      end else begin
        mq.push_back(e);
      end
    end
    m_ovr = ov || (m_ovr && !lsr_rd);
    if (wr_valid || rd_en || had == 0) m_to = 0;
    else if (baud_tick && m_to < TO) m_to++;
  endtask

  function automatic bit m_err();
    foreach (mq[i]) if (mq[i][9] || mq[i][8]) return 1;
    return 0;
  endfunction

  task automatic cyc();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p = 1'b0, input logic f = 1'b0);
    wr_valid = 1; wr_data = d; wr_pe = p; wr_fe = f;
    cyc();
    wr_valid = 0; wr_pe = 0; wr_fe = 0;
  endtask

  task automatic pop1();
    rd_en = 1; cyc(); rd_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; wr_valid = 1; wr_data = 8'h5A;
    cyc(); cyc();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (data_avail !== 1'b0) begin failures++; $display("FAIL rst_avail got=%b exp=0", data_avail); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    checks++; if ({rd_data, rd_pe, rd_fe, err_in_fifo, trig_hit, char_timeout} !== 13'd0) begin
      failures++; $display("FAIL rst_outs got=%h exp=0", {rd_data, rd_pe, rd_fe, err_in_fifo, trig_hit, char_timeout});
    end
    rst = 0; wr_valid = 0; fifo_en = 1;
    cyc();
  endtask

  task automatic test_trigger_order();
    logic [7:0] exp;
    trig_level = 2'd1;
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h11 * (i + 1)));
      if (i == 2) begin
        checks++; if (trig_hit !== 1'b0) begin failures++; $display("FAIL trig_3 got=%b exp=0", trig_hit); end
      end
    end
    checks++; if (trig_hit !== 1'b1) begin failures++; $display("FAIL trig_4 got=%b exp=1", trig_hit); end
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL trig_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      checks++; if (rd_data !== exp) begin failures++; $display("FAIL order_%0d got=%h exp=%h", i, rd_data, exp); end
      pop1();
    end
    checks++; if (data_avail !== 1'b0) begin failures++; $display("FAIL order_avail got=%b exp=0", data_avail); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovr_count got=%0d exp=16", count); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL ovr_head got=%h exp=00", rd_data); end
    lsr_rd = 1; cyc(); lsr_rd = 0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
    rd_en = 1; push(8'hAA); rd_en = 0;
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovr_rw_count got=%0d exp=16", count); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_rw_flag got=%b exp=0", overrun); end
    for (int i = 1; i < 16; i++) begin
      checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL ovr_drain_%0d got=%h exp=%h", i, rd_data, 8'(i)); end
      pop1();
    end
    checks++; if (rd_data !== 8'hAA) begin failures++; $display("FAIL ovr_tail got=%h exp=aa", rd_data); end
    pop1();
  endtask

  task automatic test_errors();
    push(8'h3C, 1'b1);
    push(8'h5A);
    checks++; if (err_in_fifo !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_in_fifo); end
    checks++; if ({rd_pe, rd_data} !== {1'b1, 8'h3C}) begin failures++; $display("FAIL err_head got=%b/%h exp=1/3c", rd_pe, rd_data); end
    pop1();
    checks++; if ({rd_pe, err_in_fifo, rd_data} !== {2'b00, 8'h5A}) begin
      failures++; $display("FAIL err_after got=%b%b/%h exp=00/5a", rd_pe, err_in_fifo, rd_data);
    end
    push(8'h81, 1'b0, 1'b1);
    pop1();
    checks++; if ({rd_fe, err_in_fifo, rd_data} !== {2'b11, 8'h81}) begin
      failures++; $display("FAIL err_fe got=%b%b/%h exp=11/81", rd_fe, err_in_fifo, rd_data);
    end
    pop1();
    checks++; if (err_in_fifo !== 1'b0) begin failures++; $display("FAIL err_empty got=%b exp=0", err_in_fifo); end
  endtask

  task automatic test_nonfifo();
    fifo_en = 0; cyc();
    push(8'h55);
    push(8'h66);
    checks++; if (rd_data !== 8'h66) begin failures++; $display("FAIL nf_data got=%h exp=66", rd_data); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL nf_ovr got=%b exp=1", overrun); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL nf_count got=%0d exp=1", count); end
    checks++; if (trig_hit !== 1'b0) begin failures++; $display("FAIL nf_trig got=%b exp=0", trig_hit); end
    lsr_rd = 1; cyc(); lsr_rd = 0;
    rd_en = 1; push(8'h77); rd_en = 0;
    checks++; if ({overrun, count, rd_data} !== {1'b0, 5'd1, 8'h77}) begin
      failures++; $display("FAIL nf_rw got=%b/%0d/%h exp=0/1/77", overrun, count, rd_data);
    end
    pop1();
  endtask

  task automatic test_timeout();
    fifo_en = 1; cyc();
    push(8'hC3);
    for (int t = 1; t <= TO; t++) begin
      baud_tick = 1; cyc(); baud_tick = 0;
      if (t == TO - 1) begin
        checks++; if (char_timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", char_timeout); end
      end
      if (t == TO) begin
        checks++; if (char_timeout !== 1'b1) begin failures++; $display("FAIL to_hit got=%b exp=1", char_timeout); end
      end
      cyc();
    end
    pop1();
    checks++; if ({char_timeout, count} !== {1'b0, 5'd0}) begin
      failures++; $display("FAIL to_clear got=%b/%0d exp=0/0", char_timeout, count);
    end
  endtask

  task automatic test_clear();
    fifo_en = 0; cyc();
    push(8'h01);
    push(8'h02);
    fifo_en = 1; cyc();
    checks++; if ({count, overrun} !== {5'd0, 1'b1}) begin
      failures++; $display("FAIL mode_flush got=%0d/%b exp=0/1", count, overrun);
    end
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), i == 2);
    checks++; if ({count, err_in_fifo} !== {5'd5, 1'b1}) begin
      failures++; $display("FAIL clr_pre got=%0d/%b exp=5/1", count, err_in_fifo);
    end
    fifo_clr = 1; push(8'hEE); fifo_clr = 0;
    checks++; if ({count, data_avail, err_in_fifo, overrun} !== {5'd0, 3'b001}) begin
      failures++; $display("FAIL clr got=%0d/%b/%b/%b exp=0/0/0/1", count, data_avail, err_in_fifo, overrun);
    end
    cyc();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL clr_drop got=%0d exp=0", count); end
  endtask

  task automatic test_random();
    int pw, pr, n;
    bit quiet, wild;
    logic [7:0] e_d;
    logic e_pe, e_fe;
    for (int ph = 0; ph < 5; ph++) begin
      pw = (ph == 0) ? 60 : (ph == 2) ? 0 : (ph == 1) ? 30 : 40;
      pr = (ph == 0) ? 30 : (ph == 2) ? 0 : (ph == 1) ? 60 : 30;
      quiet = (ph == 2);
      wild  = (ph == 4);
      n = quiet ? 800 : 600;
      fifo_en = (ph != 3);
      for (int c = 0; c < n; c++) begin
        wr_valid  = $urandom_range(0, 99) < pw;
        wr_data   = 8'($urandom);
        wr_pe     = ($urandom_range(0, 7) == 0);
        wr_fe     = ($urandom_range(0, 7) == 0);
        rd_en     = $urandom_range(0, 99) < pr;
        lsr_rd    = ($urandom_range(0, 9) == 0);
        baud_tick = quiet || ($urandom_range(0, 3) == 0);
        if (c % 50 == 0) trig_level = 2'($urandom);
        fifo_clr  = wild && ($urandom_range(0, 99) == 0);
        rst       = wild && ($urandom_range(0, 199) == 0);
        if (wild && $urandom_range(0, 99) == 0) fifo_en = ~fifo_en;
        cyc();
        e_d  = mq.size() ? mq[0][7:0] : 8'h00;
        e_pe = mq.size() ? mq[0][8] : 1'b0;
        e_fe = mq.size() ? mq[0][9] : 1'b0;
        checks++; if (count !== 5'(mq.size())) begin failures++; $display("FAIL rnd_count ph=%0d c=%0d got=%0d exp=%0d", ph, c, count, mq.size()); end
        checks++; if ({rd_data, rd_pe, rd_fe} !== {e_d, e_pe, e_fe}) begin
          failures++; $display("FAIL rnd_head ph=%0d c=%0d got=%h/%b%b exp=%h/%b%b", ph, c, rd_data, rd_pe, rd_fe, e_d, e_pe, e_fe);
        end
        checks++; if (data_avail !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_avail ph=%0d c=%0d got=%b", ph, c, data_avail); end
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL rnd_ovr ph=%0d c=%0d got=%b exp=%b", ph, c, overrun, m_ovr); end
        checks++; if (err_in_fifo !== m_err()) begin failures++; $display("FAIL rnd_err ph=%0d c=%0d got=%b exp=%b", ph, c, err_in_fifo, m_err()); end
        checks++; if (trig_hit !== (fifo_en && mq.size() >= thr[trig_level])) begin
          failures++; $display("FAIL rnd_trig ph=%0d c=%0d got=%b", ph, c, trig_hit);
        end
        checks++; if (char_timeout !== (fifo_en && mq.size() != 0 && m_to == TO)) begin
          failures++; $display("FAIL rnd_to ph=%0d c=%0d got=%b to=%0d", ph, c, char_timeout, m_to);
        end
      end
    end
    {wr_valid, rd_en, lsr_rd, fifo_clr, rst, baud_tick} = '0;
  endtask

  initial begin
    rst = 1; wr_valid = 0; wr_data = 0; wr_pe = 0; wr_fe = 0; rd_en = 0; lsr_rd = 0;
    fifo_en = 0; fifo_clr = 0; trig_level = 0; baud_tick = 0;
    test_reset();
    test_trigger_order();
    test_overrun();
    test_errors();
    test_nonfifo();
    test_timeout();
    test_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer between uart_rx and the 16550 register file.
- Captures each received character with its parity and framing flags into a 16-entry FIFO, or a 1-entry holding register in 16450 (non-FIFO) mode.
- Drives the RBR/LSR receive bits, the trigger-level status and the character-timeout status consumed by the interrupt logic.

Parameters:
- DEPTH, 16, FIFO entries; power of two.
- TIMEOUT_TICKS, 640, baud_tick count of idle time before char_timeout (4 character times at 8N1, 16x oversample).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- wr_valid  in  1  one-cycle pulse from uart_rx data_ready
- wr_data  in  8  uart_rx data_out
- wr_pe  in  1  uart_rx parity_err
- wr_fe  in  1  uart_rx framing_err
- rd_en  in  1  one-cycle pulse; host read of RBR, pops head
- lsr_rd  in  1  one-cycle pulse; host read of LSR
- fifo_en  in  1  FCR[0]
- fifo_clr  in  1  FCR[1] pulse
- trig_level  in  2  FCR[7:6]: 0→1, 1→4, 2→8, 3→14 entries
- baud_tick  in  1  free-running 16x sample tick
- rd_data  out  8  head data (RBR)
- rd_pe  out  1  head parity flag (LSR[2])
- rd_fe  out  1  head framing flag (LSR[3])
- data_avail  out  1  count != 0 (LSR[0])
- overrun  out  1  sticky overrun (LSR[1])
- err_in_fifo  out  1  any stored entry has PE or FE (LSR[7])
- count  out  5  occupancy, 0..16
- trig_hit  out  1  fifo_en and count >= trigger level
- char_timeout  out  1  character timeout status

Behaviour:
- Reset: all outputs 0; pointers, count, error counter, timeout counter 0.
- Storage: 10-bit entries {fe, pe, data}. Write/read pointers wrap modulo DEPTH.
- Error tracking: err_cnt counts stored entries with pe|fe. err_in_fifo = (err_cnt != 0).
- Head outputs: rd_data/rd_pe/rd_fe combinationally show the head entry. They are 0 when empty.
- Write latency: wr_valid at cycle N → entry visible at head and reflected in count at N+1.
- FIFO mode (fifo_en=1), effective depth DEPTH:
  - wr_valid with count<DEPTH: push.
  - wr_valid while full without rd_en: character discarded, FIFO unchanged, overrun set.
  - wr_valid with rd_en while full: pop and push both occur, count stays 16, no overrun.
- Non-FIFO mode (fifo_en=0), effective depth 1:
  - wr_valid while full: the holding entry is overwritten with the new character, overrun set.
  - wr_valid with rd_en in the same cycle: the new character is stored, no overrun.
- rd_en when empty: ignored, no underflow. rd_en and wr_valid together when empty: push only.
- Overrun clearing: lsr_rd clears overrun. If an overrun event and lsr_rd coincide, overrun stays 1. Overrun is unaffected by fifo_clr.
- fifo_clr, or any change of fifo_en (edge detected against a registered copy):
  - empties the FIFO: pointers, count and err_cnt go to 0, and the timeout counter clears.
  - a wr_valid in the same cycle is dropped.
- trig_hit: 0 whenever fifo_en=0.
- Character timeout:
  - Timeout counter is 10-bit. It resets on wr_valid, rd_en, or count==0.
  - Otherwise it increments on baud_tick, saturating at TIMEOUT_TICKS.
  - char_timeout = fifo_en & (count!=0) & (counter==TIMEOUT_TICKS).
  - It deasserts the cycle after rd_en or wr_valid.
- Reset mid-operation: takes priority over all inputs. Contents are not required to be preserved.

Decomposition:
- Shared package uart_pkg, which holds:
  - rx_entry_t typedef (fe, pe, data[7:0]);
  - trigger-level lookup constant array {1,4,8,14};
  - FIFO_DEPTH constant.
- One natural sub-module: sync_fifo. It is a generic synchronous FIFO with push, pop, full, empty and count, parameterised on width and depth. The UART-specific overrun, error, trigger and timeout logic stays in uart_rx_fifo.

Test Plan:
- fifo_en=1, trig_level=1; push 0x11,0x22,0x33,0x44 → trig_hit rises with the 4th push. rd_en×4 returns 0x11..0x44 in order, and data_avail drops after the last pop.
- Push 16 bytes 0x00..0x0F then wr_valid 0xAA → count=16, overrun=1, head still 0x00. Next lsr_rd → overrun=0. Repeat the 17th push with rd_en in the same cycle → count=16, overrun=0, tail=0xAA.
- Push 0x3C with pe=1, then 0x5A clean → err_in_fifo=1 and rd_pe=1 at the head. After one rd_en → rd_pe=0, err_in_fifo=0, rd_data=0x5A.
- fifo_en=0; push 0x55 then 0x66 without read → rd_data=0x66, overrun=1, count=1, trig_hit=0.
- fifo_en=1; push one byte, then 640 baud_ticks idle → char_timeout=1 exactly at the 640th tick. Then rd_en → char_timeout=0, count=0.
- With 5 entries stored, pulse fifo_clr together with wr_valid → count=0, data_avail=0, err_in_fifo=0. overrun keeps its prior value.
